// File: rtl/rv_plic_agent_pkg.sv
// State encoding and TL-UL constants for the PLIC claim/complete agent.
package rv_plic_agent_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLAIM_A    = 3'd1,
        ST_CLAIM_D    = 3'd2,
        ST_DELIVER    = 3'd3,
        ST_SERVICE    = 3'd4,
        ST_COMPLETE_A = 3'd5,
        ST_COMPLETE_D = 3'd6
    } agent_state_e;

    localparam logic [2:0] OpGet         = 3'h4;
    localparam logic [2:0] OpPutFullData = 3'h0;
    localparam logic [1:0] ASizeWord     = 2'd2;
    localparam logic [3:0] AMaskWord     = 4'hF;

    // Holdoff counter width; a zero holdoff still needs a 1-bit counter.
    function automatic int cnt_width(input int holdoff);
        return (holdoff < 1) ? 1 : $clog2(holdoff + 1);
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by TL-UL hosts and devices in this slice.
package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/rv_plic_claim_agent.sv
// Claims an interrupt from the PLIC CC register over TL-UL, hands the ID to the core
// with a req/ack handshake, then writes the ID back to complete it.
module rv_plic_claim_agent
    import rv_plic_agent_pkg::*;
    import tlul_pkg::*;
#(
    parameter logic [31:0] CcAddr   = 32'h0020_0004,
    parameter int          SrcW     = 7,
    parameter logic [7:0]  SourceId = 8'h00,
    parameter int          Holdoff  = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            irq_i,
    input  logic            en_i,
    output tl_h2d_t         tl_o,
    input  tl_d2h_t         tl_i,
    output logic            irq_req_o,
    output logic [SrcW-1:0] irq_id_o,
    input  logic            irq_ack_i,
    input  logic            irq_done_i,
    output logic            busy_o,
    output logic            err_o
);

    localparam int CntW = cnt_width(Holdoff);

    agent_state_e    r_state;
    agent_state_e    w_state_next;
    logic [SrcW-1:0] r_id;
    logic [SrcW-1:0] w_id_next;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;
    logic            r_err;
    logic            w_err_next;
    logic            w_unused_tl;

    always_comb begin
        w_state_next = r_state;
        w_id_next    = r_id;
        w_cnt_next   = r_cnt;
        w_err_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else if (irq_i && en_i) begin
                    w_state_next = ST_CLAIM_A;
                end
            end
            ST_CLAIM_A: begin
                if (tl_i.a_ready) w_state_next = ST_CLAIM_D;
            end
            ST_CLAIM_D: begin
                if (tl_i.d_valid) begin
                    if (tl_i.d_error) begin
                        w_err_next   = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        // A zero ID is a spurious claim: nothing to deliver or complete.
                        w_id_next    = tl_i.d_data[SrcW-1:0];
                        w_state_next = (tl_i.d_data[SrcW-1:0] == '0) ? ST_IDLE : ST_DELIVER;
                    end
                end
            end
            ST_DELIVER: begin
                if (irq_ack_i) w_state_next = irq_done_i ? ST_COMPLETE_A : ST_SERVICE;
            end
            ST_SERVICE: begin
                if (irq_done_i) w_state_next = ST_COMPLETE_A;
            end
            ST_COMPLETE_A: begin
                if (tl_i.a_ready) w_state_next = ST_COMPLETE_D;
            end
            ST_COMPLETE_D: begin
                if (tl_i.d_valid) begin
                    w_err_next   = tl_i.d_error;
                    w_cnt_next   = CntW'(Holdoff);
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_id    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_id    <= w_id_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
        end
    end

    // Request channel is decoded from state so fields stay stable while stalled.
    always_comb begin
        tl_o           = '0;
        tl_o.d_ready   = 1'b1;
        tl_o.a_size    = ASizeWord;
        tl_o.a_mask    = AMaskWord;
        tl_o.a_address = CcAddr;
        tl_o.a_source  = SourceId;
        tl_o.a_valid   = (r_state == ST_CLAIM_A) || (r_state == ST_COMPLETE_A);
        tl_o.a_opcode  = (r_state == ST_COMPLETE_A) ? OpPutFullData : OpGet;
        tl_o.a_data    = (r_state == ST_COMPLETE_A) ? 32'(r_id) : 32'h0;
    end

    assign irq_req_o = (r_state == ST_DELIVER);
    assign irq_id_o  = (r_state == ST_DELIVER) ? r_id : '0;
    assign busy_o    = (r_state != ST_IDLE);
    assign err_o     = r_err;

    assign w_unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                           tl_i.d_sink, tl_i.d_data[31:SrcW]};

endmodule

// File: tb/tb_rv_plic_claim_agent.sv
// Directed scoreboard bench: stimulus pushes expected bus requests, deliveries and error
// pulses; an independent monitor pops and compares them as the agent produces them.
module tb_rv_plic_claim_agent;
    import tlul_pkg::*;
    import rv_plic_agent_pkg::*;

    localparam logic [31:0] CC   = 32'h0020_0004;
    localparam int          HOLD = 2;
    localparam int          K_REQ = 0;
    localparam int          K_DLV = 1;
    localparam int          K_ERR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       irq = 1'b0;
    logic       en = 1'b1;
    logic       ack = 1'b0;
    logic       done = 1'b0;
    tl_h2d_t    tl_o;
    tl_d2h_t    tl_i;
    logic       irq_req;
    logic [6:0] irq_id;
    logic       busy;
    logic       err;

    logic        a_ready = 1'b1;
    logic        d_valid = 1'b0;
    logic [31:0] d_data = 32'h0;
    logic        d_error = 1'b0;
    logic [31:0] claim_data = 32'h0;
    logic        claim_err = 1'b0;
    logic        put_err = 1'b0;
    int          stall_get = 0;
    int          stall_put = 0;

    typedef struct {
        int          kind;
        logic [2:0]  op;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   dvalid_cyc = -10;
    int   req_rises = 0;
    int   err_pulses = 0;

    always #5 clk = ~clk;

    rv_plic_claim_agent #(
        .CcAddr  (CC),
        .SrcW    (7),
        .SourceId(8'h00),
        .Holdoff (HOLD)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .irq_i     (irq),
        .en_i      (en),
        .tl_o      (tl_o),
        .tl_i      (tl_i),
        .irq_req_o (irq_req),
        .irq_id_o  (irq_id),
        .irq_ack_i (ack),
        .irq_done_i(done),
        .busy_o    (busy),
        .err_o     (err)
    );

    always_comb begin
        tl_i         = '0;
        tl_i.a_ready = a_ready;
        tl_i.d_valid = d_valid;
        tl_i.d_data  = d_data;
        tl_i.d_error = d_error;
    end

    function automatic void check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    function automatic void check_tl(input string name, input tl_h2d_t act, input tl_h2d_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    function automatic void exp_push(input int kind, input logic [2:0] op, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.op   = op;
        e.data = data;
        sbq.push_back(e);
    endfunction

    function automatic void sb_pop(input string name, input int kind, output exp_t e, output bit ok);
        checks++;
        ok = 1'b0;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected output actual_kind=%0d expected=none", name, kind);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind) begin
                failures++;
                $display("FAIL %s kind actual=%0d expected=%0d", name, kind, e.kind);
            end else begin
                ok = 1'b1;
            end
        end
    endfunction

    // PLIC model: accepts requests with optional stall, answers one cycle later.
    initial begin
        bit         fire;
        logic [2:0] op;
        forever begin
            @(negedge clk);
            fire = tl_o.a_valid && a_ready;
            op   = tl_o.a_opcode;
            @(posedge clk);
            #1;
            if (fire) begin
                d_valid = 1'b1;
                if (op == OpGet) begin
                    d_data  = claim_data;
                    d_error = claim_err;
                end else begin
                    d_data  = 32'h0;
                    d_error = put_err;
                end
            end else begin
                d_valid = 1'b0;
                d_data  = 32'h0;
                d_error = 1'b0;
            end
            if (tl_o.a_valid && tl_o.a_opcode == OpGet && stall_get > 0) begin
                a_ready = 1'b0;
                stall_get--;
            end else if (tl_o.a_valid && tl_o.a_opcode == OpPutFullData && stall_put > 0) begin
                a_ready = 1'b0;
                stall_put--;
            end else begin
                a_ready = 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        logic    prev_req;
        bit      stalled;
        tl_h2d_t held;
        tl_h2d_t fixed;
        exp_t    e;
        bit      ok;
        prev_req = 1'b0;
        stalled  = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                stalled  = 1'b0;
                prev_req = irq_req;
            end else begin
                if (stalled) check_tl("a_stable_under_stall", tl_o, held);
                stalled = tl_o.a_valid && !a_ready;
                held    = tl_o;

                if (tl_o.a_valid && a_ready) begin
                    sb_pop("bus_req", K_REQ, e, ok);
                    if (ok) begin
                        check_eq("req_opcode", 32'(tl_o.a_opcode), 32'(e.op));
                        check_eq("req_data", tl_o.a_data, e.data);
                        fixed           = tl_o;
                        fixed.a_address = CC;
                        fixed.a_size    = 2'd2;
                        fixed.a_mask    = 4'hF;
                        fixed.a_source  = 8'h00;
                        fixed.a_param   = 3'h0;
                        fixed.d_ready   = 1'b1;
                        check_tl("req_fixed_fields", tl_o, fixed);
                        $display("txn bus %s data=0x%0h", (tl_o.a_opcode == OpGet) ? "Get" : "PutFullData", tl_o.a_data);
                    end
                end

                if (d_valid) dvalid_cyc = cyc;

                if (irq_req && !prev_req) begin
                    req_rises++;
                    sb_pop("deliver", K_DLV, e, ok);
                    if (ok) begin
                        check_eq("deliver_id", 32'(irq_id), e.data);
                        check_eq("deliver_latency", 32'(cyc - dvalid_cyc), 32'd1);
                        $display("txn deliver id=%0d", irq_id);
                    end
                end
                prev_req = irq_req;

                if (err) begin
                    err_pulses++;
                    sb_pop("err_pulse", K_ERR, e, ok);
                    $display("txn err_o pulse");
                end
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        @(negedge clk);
        while (!irq_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_req_bound", 32'(irq_req), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_idle_bound", 32'(busy), 32'd0);
    endtask

    // Raise irq until the claim request appears, then drop it.
    task automatic claim_start();
        int n = 0;
        @(posedge clk);
        #1 irq = 1'b1;
        @(negedge clk);
        while (!tl_o.a_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("claim_start_bound", 32'(tl_o.a_valid), 32'd1);
        @(posedge clk);
        #1 irq = 1'b0;
    endtask

    task automatic pulse_ack(input logic with_done);
        @(posedge clk);
        #1;
        ack  = 1'b1;
        done = with_done;
        @(posedge clk);
        #1;
        ack  = 1'b0;
        done = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rises_before;
        int errs_before;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_a_valid", 32'(tl_o.a_valid), 32'd0);
        check_eq("rst_d_ready", 32'(tl_o.d_ready), 32'd1);
        check_eq("rst_irq_req", 32'(irq_req), 32'd0);
        check_eq("rst_irq_id", 32'(irq_id), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic flow; upper claim data bits must be ignored
        claim_data = 32'hA5A5_A585;
        exp_push(K_REQ, OpGet, 32'h0);
        exp_push(K_DLV, 3'h0, 32'd5);
        @(posedge clk);
        #1 irq = 1'b1;
        @(negedge clk);
        check_eq("lat_irq_pre", 32'(tl_o.a_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_irq_to_a", 32'(tl_o.a_valid), 32'd1);
        @(posedge clk);
        #1 irq = 1'b0;
        wait_req();
        en = 1'b0;
        pulse_ack(1'b0);
        @(negedge clk);
        check_eq("service_req_low", 32'(irq_req), 32'd0);
        check_eq("service_busy", 32'(busy), 32'd1);
        exp_push(K_REQ, OpPutFullData, 32'd5);
        @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        en   = 1'b1;
        irq  = 1'b1;
        @(negedge clk);
        check_eq("lat_done_to_a", 32'(tl_o.a_valid), 32'd1);

        // Holdoff gap, followed by a spurious claim (low bits zero)
        claim_data = 32'hFFFF_FF80;
        exp_push(K_REQ, OpGet, 32'h0);
        rises_before = req_rises;
        wait_idle();
        n = 0;
        while (!tl_o.a_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check_eq("holdoff_gap", 32'(n), 32'(HOLD + 1));
        @(posedge clk);
        #1 irq = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        check_eq("spurious_no_req", 32'(req_rises), 32'(rises_before));
        check_eq("spurious_idle", 32'(busy), 32'd0);

        // Backpressure on both request phases
        claim_data = 32'd12;
        stall_get  = 4;
        stall_put  = 4;
        exp_push(K_REQ, OpGet, 32'h0);
        exp_push(K_DLV, 3'h0, 32'd12);
        claim_start();
        wait_req();
        check_eq("stall_get_used", 32'(stall_get), 32'd0);
        exp_push(K_REQ, OpPutFullData, 32'd12);
        pulse_ack(1'b0);
        pulse_done();
        wait_idle();
        check_eq("stall_put_used", 32'(stall_put), 32'd0);

        // ack and done together skip SERVICE
        claim_data = 32'd63;
        exp_push(K_REQ, OpGet, 32'h0);
        exp_push(K_DLV, 3'h0, 32'd63);
        claim_start();
        wait_req();
        exp_push(K_REQ, OpPutFullData, 32'd63);
        pulse_ack(1'b1);
        @(negedge clk);
        check_eq("simul_a_valid", 32'(tl_o.a_valid), 32'd1);
        check_eq("simul_opcode", 32'(tl_o.a_opcode), 32'(OpPutFullData));
        check_eq("simul_req_low", 32'(irq_req), 32'd0);
        wait_idle();

        // Error on claim
        errs_before = err_pulses;
        claim_data  = 32'd5;
        claim_err   = 1'b1;
        exp_push(K_REQ, OpGet, 32'h0);
        exp_push(K_ERR, 3'h0, 32'h0);
        claim_start();
        wait_idle();
        claim_err = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("claim_err_pulses", 32'(err_pulses - errs_before), 32'd1);
        check_eq("claim_err_idle", 32'(busy), 32'd0);

        // Error on complete
        claim_data = 32'd7;
        put_err    = 1'b1;
        exp_push(K_REQ, OpGet, 32'h0);
        exp_push(K_DLV, 3'h0, 32'd7);
        claim_start();
        wait_req();
        pulse_ack(1'b0);
        exp_push(K_REQ, OpPutFullData, 32'd7);
        exp_push(K_ERR, 3'h0, 32'h0);
        pulse_done();
        wait_idle();
        put_err = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("put_err_pulses", 32'(err_pulses - errs_before), 32'd2);
        check_eq("put_err_idle", 32'(busy), 32'd0);

        // Reset in DELIVER abandons id 9; a stray done afterwards is ignored
        claim_data = 32'd9;
        exp_push(K_REQ, OpGet, 32'h0);
        exp_push(K_DLV, 3'h0, 32'd9);
        claim_start();
        wait_req();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_irq_req", 32'(irq_req), 32'd0);
        check_eq("midrst_a_valid", 32'(tl_o.a_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        pulse_done();
        @(negedge clk);
        check_eq("stray_done_a_valid", 32'(tl_o.a_valid), 32'd0);
        check_eq("stray_done_busy", 32'(busy), 32'd0);
        claim_data = 32'd4;
        exp_push(K_REQ, OpGet, 32'h0);
        exp_push(K_DLV, 3'h0, 32'd4);
        claim_start();
        wait_req();
        pulse_ack(1'b0);
        exp_push(K_REQ, OpPutFullData, 32'd4);
        pulse_done();
        wait_idle();

        // Disabled agent does not claim
        en = 1'b0;
        @(posedge clk);
        #1 irq = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("disabled_busy", 32'(busy), 32'd0);
        check_eq("disabled_a_valid", 32'(tl_o.a_valid), 32'd0);
        @(posedge clk);
        #1;
        irq = 1'b0;
        en  = 1'b1;

        repeat (5) @(negedge clk);
        check_eq("sb_drain", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
